boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//   Serial program loader directly upstream of the 4096x8 RAM. Consumes a byte stream from the UART
//   receiver, parses one framed image and writes it into RAM via the RAM's addr/data_in/we port.
//   Holds the CPU (cpu_hold) until a frame with a good checksum has been loaded.
//   Frame: 0xA5, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes, CSUM.
// PARAMETERS
//   SYNC_BYTE      8'hA5   frame start marker
//   TIMEOUT_CYCLES 100000  max clk cycles between bytes inside a frame before abort
//   HOLD_ON_RESET  1       1: cpu_hold=1 out of reset; 0: cpu_hold=0 until a SYNC byte arrives
// PORTS
//   clk        in   1   single clock; all logic on posedge
//   reset      in   1   synchronous, active-high
//   rx_valid   in   1   one-cycle strobe: rx_data holds a received byte
//   rx_data    in   8   received byte
//   mem_addr   out  12  RAM address (drives RAM addr while cpu_hold=1)
//   mem_data   out  8   RAM write data
//   mem_we     out  1   RAM write enable, one-cycle pulse per data byte
//   cpu_hold   out  1   1 = CPU held in reset, loader owns RAM port
//   busy       out  1   1 = frame in progress (state != SYNC)
//   load_done  out  1   one-cycle pulse on good checksum
//   load_error out  1   sticky; set on bad checksum or timeout, cleared on next SYNC byte
// BEHAVIOUR
//   Reset: state=SYNC, mem_addr=0, mem_data=0, mem_we=0, busy=0, load_done=0, load_error=0,
//     cpu_hold=HOLD_ON_RESET, sum=0, len=0, timer=0. Reset mid-frame aborts; no partial state kept.
//   All outputs registered. The loader never back-pressures; rx_valid is accepted every cycle.
//   States: SYNC -> AHI -> ALO -> LHI -> LLO -> DATA -> CSUM -> SYNC; each advance on rx_valid.
//   SYNC: rx_data==SYNC_BYTE -> AHI, load_error<=0, cpu_hold<=1, sum<=0; other bytes ignored.
//   AHI/ALO: address = {AHI[3:0], ALO}; upper nibble of AHI ignored.
//   LHI/LLO: len = {LHI[3:0], LLO}; upper nibble of LHI ignored.
//     LLO leaves to DATA if len!=0, else straight to CSUM.
//   DATA: byte accepted in cycle N -> cycle N+1: mem_we=1, mem_addr=current address, mem_data=byte.
//     Address then increments mod 4096 (0xFFF wraps to 0x000). sum <= sum+byte (mod 256). len
//     decrements; the byte that brings len to 0 moves state to CSUM.
//   CSUM: rx_data==sum -> load_done pulse (1 cycle), cpu_hold<=0, SYNC.
//     Mismatch -> load_error<=1, cpu_hold stays 1, SYNC. RAM is already written on mismatch;
//     corrupted contents are tolerated because the CPU stays held.
//   Timeout: timer clears on every rx_valid and counts otherwise in every state != SYNC.
//     Reaching TIMEOUT_CYCLES-1 -> load_error<=1, SYNC, cpu_hold stays 1.
//     rx_valid in the same cycle as expiry takes priority: byte accepted, no timeout.
//   A SYNC_BYTE value inside a frame is plain data, with no resync.
//   While cpu_hold=0, no mem_we is issued. A new SYNC re-asserts cpu_hold on the next cycle.
//   busy = (state != SYNC), registered alongside state.
// STRUCTURE
//   boot_loader_defs.vh: state encodings (3-bit localparams), default SYNC_BYTE, header byte count.
//   One sub-module, boot_timeout: counter with clear/enable inputs and an expired output,
//     width $clog2(TIMEOUT_CYCLES). Top level holds the FSM, address/len/sum registers and
//     output registers.
//   The RAM-port mux between the loader and the CPU (selected by cpu_hold) lives in the top level,
//   not here.
// TESTING
//   1 Reset -> cpu_hold=1, busy=0, mem_we=0. Send A5 01 00 00 03 11 22 33 66 ->
//     writes 0x100=11, 0x101=22, 0x102=33 (one mem_we each, 1 cycle after byte);
//     load_done pulses once; cpu_hold=0.
//   2 Same frame with CSUM=67 -> 3 writes occur, load_error=1, cpu_hold=1, no load_done.
//     Then a good frame -> load_error clears at its A5; frame completes.
//   3 Wrap: A5 0F FF 00 02 AA BB 65 -> writes 0xFFF=AA, 0x000=BB; load_done pulses.
//   4 Zero length: A5 00 00 00 00 00 -> no mem_we, load_done pulses.
//     Junk bytes 00 FF before A5 are ignored.
//   5 Timeout (TIMEOUT_CYCLES=16): A5 00 00 then silence -> load_error=1 after 16 idle cycles,
//     busy=0, cpu_hold=1. A byte arriving exactly on the expiry cycle is accepted, no error.
//   6 Assert reset during DATA after 1 of 3 bytes -> next cycle all outputs at reset values.
//     A following full frame loads correctly.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding, defaults and helpers for the boot loader
package boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_LHI  = 3'd3,
    ST_LLO  = 3'd4,
    ST_DATA = 3'd5,
    ST_CSUM = 3'd6
  } state_t;

  // Header fields are 12 bits wide: low nibble of the high byte joined with the low byte
  function automatic logic [11:0] cat12(input logic [3:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/boot_loader_timeout.sv
// rtl/boot_loader_timeout.sv - inter-byte idle counter with clear/enable and expiry flag
module boot_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count idle cycles; saturate at the last value so the flag cannot wrap away
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed serial image loader writing into the 4096x8 program RAM
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter bit         HOLD_ON_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);

  state_t      state;
  logic [11:0] addr_q;
  logic [11:0] len_q;
  logic [7:0]  sum_q;
  logic        tmo_expired;

  // The timer only runs mid-frame and restarts on every received byte
  boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || (state == ST_SYNC)),
    .enable  (state != ST_SYNC),
    .expired (tmo_expired)
  );

  // Frame parser: header capture, RAM writes, checksum verdict and timeout abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SYNC;
      addr_q     <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cpu_hold   <= HOLD_ON_RESET;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state      <= ST_AHI;
              busy       <= 1'b1;
              load_error <= 1'b0;
              cpu_hold   <= 1'b1;
              sum_q      <= '0;
            end
          end
          ST_AHI: begin
            addr_q[11:8] <= rx_data[3:0];
            state        <= ST_ALO;
          end
          ST_ALO: begin
            addr_q[7:0] <= rx_data;
            state       <= ST_LHI;
          end
          ST_LHI: begin
            len_q[11:8] <= rx_data[3:0];
            state       <= ST_LLO;
          end
          ST_LLO: begin
            len_q[7:0] <= rx_data;
            if (cat12(len_q[11:8], rx_data) != 12'd0) begin
              state <= ST_DATA;
            end else begin
              state <= ST_CSUM;
            end
          end
          ST_DATA: begin
            // cpu_hold is always set here; the gate keeps the CPU's RAM port safe regardless
            mem_we   <= cpu_hold;
            mem_addr <= addr_q;
            mem_data <= rx_data;
            addr_q   <= addr_q + 12'd1;
            sum_q    <= sum_q + rx_data;
            len_q    <= len_q - 12'd1;
            if (len_q == 12'd1) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_data == sum_q) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
            state <= ST_SYNC;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_SYNC;
            busy  <= 1'b0;
          end
        endcase
      end else if (tmo_expired && (state != ST_SYNC)) begin
        load_error <= 1'b1;
        state      <= ST_SYNC;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed and randomized checks of boot_loader against a frame-level model
module tb_boot_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int done_cnt = 0;
  int viol = 0;

  logic [7:0] frame_q[$];
  int byte_cyc[$];
  int obs_addr[$];
  int obs_data[$];
  int obs_cyc[$];
  int exp_addr[$];
  int exp_data[$];
  int exp_cyc[$];

  boot_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (16),
    .HOLD_ON_RESET  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(int'(mem_data));
      obs_cyc.push_back(cyc);
      if (!cpu_hold) viol = viol + 1;
    end
    if (load_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic set_frame(input logic [7:0] b[]);
    frame_q.delete();
    foreach (b[i]) frame_q.push_back(b[i]);
  endtask

  // Frame-level reference: skip to the first sync, decode the header, list the expected writes
  task automatic build_expect(output bit good);
    int s;
    int a;
    int n;
    int sum;
    exp_addr.delete();
    exp_data.delete();
    exp_cyc.delete();
    s = 0;
    while (frame_q[s] != SYNC) s++;
    a = (int'(frame_q[s+1]) % 16) * 256 + int'(frame_q[s+2]);
    n = (int'(frame_q[s+3]) % 16) * 256 + int'(frame_q[s+4]);
    sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((a + i) % 4096);
      exp_data.push_back(int'(frame_q[s+5+i]));
      exp_cyc.push_back(byte_cyc[s+5+i] + 1);
      sum = sum + int'(frame_q[s+5+i]);
    end
    good = (int'(frame_q[s+5+n]) == (sum % 256));
  endtask

  task automatic run_frame(input int maxgap);
    int sidx;
    int d0;
    bit good;
    int nw;
    sidx = 0;
    while (frame_q[sidx] != SYNC) sidx++;
    d0 = done_cnt;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    byte_cyc.delete();
    foreach (frame_q[i]) begin
      present(frame_q[i]);
      byte_cyc.push_back(last_cyc);
      if (i < sidx) check("junk_busy", busy, 0);
      if (i == sidx) begin
        check("sync_err_clear", load_error, 0);
        check("sync_hold", cpu_hold, 1);
        check("sync_busy", busy, 1);
      end
      if (i < frame_q.size() - 1) idle($urandom_range(0, maxgap));
    end
    idle(2);
    build_expect(good);
    nw = exp_addr.size();
    check("write_count", obs_addr.size(), nw);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      check("write_addr", obs_addr[i], exp_addr[i]);
      check("write_data", obs_data[i], exp_data[i]);
      check("write_cycle", obs_cyc[i], exp_cyc[i]);
    end
    check("done_pulses", done_cnt - d0, good ? 1 : 0);
    check("end_error", load_error, good ? 0 : 1);
    check("end_hold", cpu_hold, good ? 0 : 1);
    check("end_busy", busy, 0);
    check("we_while_released", viol, 0);
  endtask

  task automatic gen_frame(input int r);
    int addr;
    int len;
    int sum;
    logic [7:0] b;
    frame_q.delete();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h5A;
      frame_q.push_back(b);
    end
    addr = (r % 3 == 0) ? 4096 - $urandom_range(1, 8) : $urandom_range(0, 4095);
    len  = $urandom_range(0, 20);
    frame_q.push_back(SYNC);
    frame_q.push_back(8'(($urandom & 32'hF0) | (addr / 256)));
    frame_q.push_back(8'(addr % 256));
    frame_q.push_back(8'(($urandom & 32'hF0) | (len / 256)));
    frame_q.push_back(8'(len % 256));
    sum = 0;
    for (int i = 0; i < len; i++) begin
      b = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
      frame_q.push_back(b);
      sum = sum + int'(b);
    end
    if ($urandom_range(0, 2) == 0) sum = sum + $urandom_range(1, 255);
    frame_q.push_back(8'(sum % 256));
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_error, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);

    set_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    run_frame(0);
    set_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67});
    run_frame(2);
    set_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    run_frame(2);
    set_frame('{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65});
    run_frame(1);
    set_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_frame(1);

    for (int r = 0; r < 10; r++) begin
      gen_frame(r);
      run_frame(5);
    end

    present(8'hA5);
    present(8'h00);
    present(8'h00);
    idle(15);
    check("tmo_not_yet_err", load_error, 0);
    check("tmo_not_yet_busy", busy, 1);
    idle(1);
    check("tmo_err", load_error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_hold", cpu_hold, 1);

    d0 = done_cnt;
    present(8'hA5);
    present(8'h00);
    present(8'h00);
    idle(15);
    present(8'h00);
    check("expiry_byte_err", load_error, 0);
    check("expiry_byte_busy", busy, 1);
    present(8'h00);
    present(8'h00);
    idle(2);
    check("expiry_frame_done", done_cnt - d0, 1);
    check("expiry_frame_hold", cpu_hold, 0);

    present(8'hA5);
    present(8'h01);
    present(8'h00);
    present(8'h00);
    present(8'h03);
    present(8'h11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_err", load_error, 0);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", mem_data, 0);
    set_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
